// File: rtl/det_collect.sv
// rtl/det_collect.sv - detection collector: threshold, index-to-(row,col) decode, hit FIFO
// Optional: define DET_SCORE_OUT_EN to carry the SVM score through the FIFO to o_score.
module det_collect #(
    parameter int SW_W    = 11,
    parameter int SCORE_W = 24,
    parameter int COL_N   = 39,
    parameter int ROW_N   = 29,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 6,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [SW_W-1:0]    i_sw_id,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [SCORE_W-1:0] i_thresh,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ROW_W-1:0]   o_row,
    output logic [COL_W-1:0]   o_col,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_frame_done,
    output logic [SW_W-1:0]    o_hit_cnt,
    output logic               o_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
`ifdef DET_SCORE_OUT_EN
    localparam int ENT_W = ROW_W + COL_W + SCORE_W;
`else
    localparam int ENT_W = ROW_W + COL_W;
`endif
    localparam logic [SW_W-1:0]    MAX_ID   = SW_W'(COL_N * ROW_N - 1);
    localparam logic [SW_W-1:0]    COL_STEP = SW_W'(COL_N);
    localparam logic [ROW_W-1:0]   ROW_MAX  = '1;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEEK, S_PUSH} state_t;
    state_t state, state_nx;

    logic [SW_W-1:0]    id_r, rem_r, base_r, hit_acc, hit_cnt_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic               hit_r, frame_done_r, overflow_r;
`ifdef DET_SCORE_OUT_EN
    logic [SCORE_W-1:0] score_r;
`endif

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, push, pop, hit_drop, in_drop;
    logic [ENT_W-1:0]   head, entry;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_valid) state_nx = S_SEEK;
            S_SEEK:  if (rem_r < COL_STEP) state_nx = S_PUSH;
            S_PUSH:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign full     = (count == FULL_CNT);
    assign o_valid  = (count != '0);
    assign pop      = o_valid && i_ready;
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign push     = (state == S_PUSH) && hit_r && !full;
    assign hit_drop = (state == S_PUSH) && hit_r && full;
    assign in_drop  = i_valid && (state != S_IDLE);
    assign o_busy   = (state != S_IDLE);

`ifdef DET_SCORE_OUT_EN
    assign entry = {row_r, col_r, score_r};
`else
    assign entry = {row_r, col_r};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            id_r         <= '0;
            rem_r        <= '0;
            base_r       <= '0;
            row_r        <= '0;
            col_r        <= '0;
            hit_r        <= 1'b0;
            hit_acc      <= '0;
            hit_cnt_r    <= '0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
`ifdef DET_SCORE_OUT_EN
            score_r      <= '0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            if (in_drop || hit_drop) overflow_r <= 1'b1;
            case (state)
                S_IDLE: if (i_valid) begin
                    id_r  <= i_sw_id;
                    hit_r <= ($signed(i_score) > $signed(i_thresh));
`ifdef DET_SCORE_OUT_EN
                    score_r <= i_score;
`endif
                    // Going backwards means a new frame: restart the decode from row 0.
                    if (i_sw_id < base_r) begin
                        base_r <= '0;
                        row_r  <= '0;
                        rem_r  <= i_sw_id;
                    end else begin
                        rem_r  <= i_sw_id - base_r;
                    end
                end
                S_SEEK: begin
                    if (rem_r >= COL_STEP) begin
                        rem_r  <= rem_r - COL_STEP;
                        base_r <= base_r + COL_STEP;
                        if (row_r != ROW_MAX) row_r <= row_r + 1'b1;
                    end else begin
                        col_r <= rem_r[COL_W-1:0];
                    end
                end
                S_PUSH: begin
                    if (push) hit_acc <= hit_acc + 1'b1;
                    if (id_r == MAX_ID) begin
                        frame_done_r <= 1'b1;
                        hit_cnt_r    <= hit_acc + SW_W'(push);
                        hit_acc      <= '0;
                        base_r       <= '0;
                        row_r        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign o_row = o_valid ? head[ENT_W-1 -: ROW_W] : '0;
    assign o_col = o_valid ? head[ENT_W-ROW_W-1 -: COL_W] : '0;
`ifdef DET_SCORE_OUT_EN
    assign o_score = o_valid ? head[SCORE_W-1:0] : '0;
`else
    assign o_score = '0;
`endif

    assign o_frame_done = frame_done_r;
    assign o_hit_cnt    = hit_cnt_r;
    assign o_overflow   = overflow_r;

endmodule

// File: tb/tb_det_collect.sv
// tb/tb_det_collect.sv - scoreboard bench for det_collect
module tb_det_collect;
    localparam int SW_W    = 11;
    localparam int SCORE_W = 24;
    localparam int COL_N   = 39;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 6;
    localparam int ENT_W   = ROW_W + COL_W + SCORE_W;

    logic               clk = 1'b0;
    logic               rst, i_valid, i_ready;
    logic [SW_W-1:0]    i_sw_id;
    logic [SCORE_W-1:0] i_score, i_thresh;
    logic               o_busy, o_valid, o_frame_done, o_overflow;
    logic [ROW_W-1:0]   o_row;
    logic [COL_W-1:0]   o_col;
    logic [SCORE_W-1:0] o_score;
    logic [SW_W-1:0]    o_hit_cnt;

    logic [ENT_W-1:0]   exp_q[$];
    logic [SW_W-1:0]    fd_q[$];
    int n_cmp = 0, n_err = 0, n_fd = 0;

    always #5 clk = ~clk;

    det_collect dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sw_id(i_sw_id),
        .i_score(i_score), .i_thresh(i_thresh), .o_busy(o_busy),
        .o_valid(o_valid), .i_ready(i_ready), .o_row(o_row), .o_col(o_col),
        .o_score(o_score), .o_frame_done(o_frame_done),
        .o_hit_cnt(o_hit_cnt), .o_overflow(o_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_hit(input int id, input int score);
        logic [ROW_W-1:0]   r;
        logic [COL_W-1:0]   c;
        logic [SCORE_W-1:0] s;
        r = ROW_W'(id / COL_N);
        c = COL_W'(id % COL_N);
`ifdef DET_SCORE_OUT_EN
        s = SCORE_W'(score);
`else
        s = '0;
`endif
        exp_q.push_back({r, c, s});
    endtask

    // Scoreboard monitor: checks every accepted FIFO head and every frame_done pulse.
    always @(negedge clk) begin
        logic [ENT_W-1:0] e;
        if (!rst) begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 32'(o_row), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_row", 32'(o_row), 32'(e[ENT_W-1 -: ROW_W]));
                    chk("pop_col", 32'(o_col), 32'(e[ENT_W-ROW_W-1 -: COL_W]));
                    chk("pop_score", 32'(o_score), 32'(e[SCORE_W-1:0]));
                end
            end
            if (o_frame_done) begin
                n_fd++;
                if (fd_q.size() == 0) chk("unexpected_frame_done", 32'(o_hit_cnt), 32'hffff_ffff);
                else chk("frame_hit_cnt", 32'(o_hit_cnt), 32'(fd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 200) begin
            tick();
            n++;
        end
        chk("busy_timeout", 32'(o_busy), 0);
    endtask

    task automatic drain();
        int n = 0;
        i_ready = 1'b1;
        while (o_valid && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(o_valid), 0);
    endtask

    task automatic send(input int id, input int score, input int thresh);
        i_valid  = 1'b1;
        i_sw_id  = SW_W'(id);
        i_score  = SCORE_W'(score);
        i_thresh = SCORE_W'(thresh);
        tick();
        i_valid = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_sw_id = '0; i_score = '0; i_thresh = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_row", 32'(o_row), 0);
        chk("rst_col", 32'(o_col), 0);
        chk("rst_score", 32'(o_score), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_hit_cnt", 32'(o_hit_cnt), 0);
        chk("rst_overflow", 32'(o_overflow), 0);

        // id 552 -> row 14 col 6, o_valid visible at t+17
        expect_hit(552, 100);
        i_valid = 1'b1; i_sw_id = 11'd552; i_score = 24'd100; i_thresh = 24'd50;
        tick();
        i_valid = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 15) chk("valid_before_t17", 32'(o_valid), 0);
            if (n == 16) chk("valid_at_t17", 32'(o_valid), 1);
        end

        // equal score is not a hit; busy for two cycles only
        i_valid = 1'b1; i_sw_id = 11'd553; i_score = 24'd50; i_thresh = 24'd50;
        tick();
        i_valid = 1'b0;
        tick();
        chk("busy_t2", 32'(o_busy), 1);
        tick();
        chk("busy_t3", 32'(o_busy), 0);
        drain();
        chk("q_empty_1", 32'(exp_q.size()), 0);

        // full frame 552..1130 with hits at 600 and 1130, negative scores elsewhere
        do_reset();
        i_ready = 1'b1;
        fd_q.push_back(11'd2);
        for (int id = 552; id <= 1130; id++) begin
            if (id == 600 || id == 1130) begin
                expect_hit(id, 1000);
                send(id, 1000, 0);
            end else begin
                send(id, -5, 0);
            end
        end
        drain();
        chk("frame_pulses", 32'(n_fd), 1);
        chk("frame_hit_cnt_hold", 32'(o_hit_cnt), 2);
        chk("q_empty_2", 32'(exp_q.size()), 0);

        // 17 hits into a stalled FIFO: 16 held, one lost
        i_ready = 1'b0;
        chk("ovf_before_fill", 32'(o_overflow), 0);
        for (int id = 0; id < 17; id++) begin
            if (id < 16) expect_hit(id, -10);
            send(id, -10, -20);
        end
        chk("ovf_after_fill", 32'(o_overflow), 1);
        chk("valid_full", 32'(o_valid), 1);
        drain();
        chk("q_empty_3", 32'(exp_q.size()), 0);

        // back-to-back i_valid: second dropped
        do_reset();
        chk("ovf_cleared", 32'(o_overflow), 0);
        i_ready = 1'b1;
        expect_hit(552, 7);
        i_valid = 1'b1; i_sw_id = 11'd552; i_score = 24'd7; i_thresh = 24'd0;
        tick();
        i_sw_id = 11'd100;
        tick();
        i_valid = 1'b0;
        wait_idle();
        chk("ovf_drop", 32'(o_overflow), 1);
        drain();
        chk("q_empty_4", 32'(exp_q.size()), 0);

        // reset mid-SEEK discards the window
        do_reset();
        i_ready = 1'b1;
        i_valid = 1'b1; i_sw_id = 11'd1130; i_score = 24'd9; i_thresh = 24'd0;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        chk("busy_in_seek", 32'(o_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("busy_after_rst", 32'(o_busy), 0);
        repeat (40) tick();
        chk("no_push_after_rst", 32'(o_valid), 0);
        chk("no_frame_after_rst", 32'(n_fd), 1);
        fd_q.push_back(11'd1);
        expect_hit(1130, 9);
        send(1130, 9, 0);
        drain();
        repeat (3) tick();
        chk("frame_pulses_end", 32'(n_fd), 2);
        chk("hit_cnt_end", 32'(o_hit_cnt), 1);
        chk("q_empty_end", 32'(exp_q.size()), 0);
        chk("fd_q_empty_end", 32'(fd_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/det_collect.md
# det_collect

Detection collector at the downstream end of the SVM window stream. Consumes the per-window result strobe, window index and SVM score that the SVM controller/classifier path produces. Thresholds each score, converts the linear slide-window index back to (row, col) with an iterative subtractor, and queues hits in a FIFO behind a valid/ready handshake for the bounding-box/output stage. Also flags end-of-frame and reports the per-frame hit count.

## Interface
- SW_W, 11, slide-window index width
- SCORE_W, 24, signed SVM score width
- COL_N, 39, windows per row
- ROW_N, 29, rows per frame; last index MAX_SW = COL_N*ROW_N-1 = 1130
- ROW_W, 5, row output width
- COL_W, 6, column output width
- FIFO_AW, 4, FIFO address width; depth 2^FIFO_AW = 16
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  window result strobe, one cycle per window
- i_sw_id  in  SW_W  linear window index, valid with i_valid
- i_score  in  SCORE_W  signed SVM score, valid with i_valid
- i_thresh  in  SCORE_W  signed detection threshold, sampled with i_valid
- o_busy  out  1  high when FSM is not IDLE
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accept; pop when o_valid & i_ready
- o_row  out  ROW_W  head entry row
- o_col  out  COL_W  head entry column
- o_score  out  SCORE_W  head entry score (see Configuration)
- o_frame_done  out  1  one-cycle pulse when window MAX_SW is processed
- o_hit_cnt  out  SW_W  hits of last completed frame
- o_overflow  out  1  sticky: input or hit dropped

## Operation
- FSM states IDLE, SEEK, PUSH.
- IDLE, i_valid=1: latch id, score, hit = (i_score > i_thresh, signed, strict). Go to SEEK.
  - If id < base_r, reload base_r=0, row_r=0 (new frame or out-of-order).
  - rem = id - base_r.
- SEEK, per cycle:
  - rem >= COL_N: rem -= COL_N; base_r += COL_N; row_r += 1; stay in SEEK.
  - Else: col = rem; go to PUSH.
- PUSH, one cycle:
  - If hit: FIFO not full -> write {row_r, col, score}, hit_acc += 1. FIFO full -> discard entry, set o_overflow.
  - If id == MAX_SW: pulse o_frame_done; o_hit_cnt <= final hit_acc (including this window); hit_acc=0; base_r=0; row_r=0.
  - Return to IDLE.
- base_r/row_r persist between windows so monotonic ids decode in 0-1 SEEK steps.
- i_valid while o_busy=1: input dropped, o_overflow set, FSM unaffected.
- FIFO: simultaneous push and pop when full is a legal pop only; the push is dropped, since fullness is checked before the pop.
- o_overflow clears only on rst.
- Ids > MAX_SW are out of contract. o_row then saturates wrap-free at ROW_W bits; not checked.

## Timing
- i_valid sampled at edge t; k = rows advanced. SEEK occupies k+1 cycles; PUSH at t+k+2.
- o_frame_done is high in the cycle after the PUSH edge.
- FIFO write at the PUSH edge; o_valid rises one cycle later (t+k+3) if the FIFO was empty.
- Minimum i_valid spacing without drop: k+3 cycles.
- Pop visible the cycle after the o_valid & i_ready edge.
- Reset values: o_busy=0, o_valid=0, o_row=0, o_col=0, o_score=0, o_frame_done=0, o_hit_cnt=0, o_overflow=0. FIFO empty; base_r=row_r=hit_acc=0.
- rst mid-SEEK/PUSH: FSM returns to IDLE next cycle; the in-flight window is discarded with no push and no frame_done.

## Configuration
- DET_SCORE_OUT_EN defined: score stored in the FIFO; o_score carries the head score.
- Not defined: FIFO entries hold {row, col} only; o_score is tied to 0; threshold behaviour unchanged.

## Test plan
- After rst, i_valid with id=552, score=100, thresh=50 -> o_valid at t+17 with o_row=14, o_col=6, o_score=100.
- Then id=553, score=50, thresh=50 -> no push (equal is not a hit); o_busy low again at t+3.
- Full frame of ids 552..1130, hits on ids 600 and 1130 -> rows 15/28, cols 15/38; o_frame_done one pulse; o_hit_cnt=2.
- i_ready=0, 17 consecutive hits -> 16 entries held, o_overflow=1. Then i_ready=1 -> 16 pops in order, o_valid falls.
- i_valid at id=552 then again 1 cycle later -> second dropped, o_overflow=1, first decodes correctly.
- rst asserted during SEEK for id=1130 -> no FIFO write, no o_frame_done. Next id=1130 decodes as row 28, col 38.
